r0: RTL and testbench

//  - Small register-file RAM: 4 words x 4 bits. Storage element of the LMC R0 datapath.
//  - Synchronous write on every rising clock edge to the word selected by adr.
//  - Asynchronous (combinational) read of the word selected by the same adr.
//  - Acts as the simplest memory primitive for the LMC CPU experiments.

---
 rtl/r0_pkg.sv | 10 +
 rtl/r0_word.sv | 26 ++
 rtl/r0.sv | 49 ++++
 tb/tb_r0.sv | 138 +++++++++++++
 4 files changed

// File: rtl/r0_pkg.sv
// Shared constants and types for the R0 register-file RAM.
package r0_pkg;

    localparam int R0_ADDR_W = 2;
    localparam int R0_DATA_W = 4;
    localparam int R0_DEPTH  = 4;

    typedef logic [R0_DATA_W-1:0] r0_word_t;

endpackage : r0_pkg

// File: rtl/r0_word.sv
// One storage word of the R0 RAM: a DATA_W register with asynchronous
// active-low clear and a write enable.
module r0_word #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] r_q;

    // Clear on reset (takes priority over any edge); otherwise load d when selected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (we) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule : r0_word

// File: rtl/r0.sv
// R0 register-file RAM: 2**ADDR_W words of DATA_W bits. Every rising clock
// edge writes data_in to the addressed word (there is no write enable);
// the same address drives a combinational read of the stored array, so a
// freshly written value appears on RAM_out right after the edge.
module r0
    import r0_pkg::*;
#(
    parameter int ADDR_W = R0_ADDR_W,
    parameter int DATA_W = R0_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] adr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] RAM_out
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0]  w_we;
    logic [DATA_W-1:0] w_q [DEPTH];

    // One-hot write decode: exactly one word is selected for every valid adr.
    always_comb begin
        w_we = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_we[i] = (adr == ADDR_W'(i));
        end
    end

    // Storage array, one register per word.
    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        r0_word #(
            .DATA_W (DATA_W)
        ) u_word (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (w_we[g]),
            .d     (data_in),
            .q     (w_q[g])
        );
    end

    // Combinational read of the stored word; an X address yields X in simulation.
    always_comb begin
        RAM_out = w_q[adr];
    end

endmodule : r0

// File: tb/tb_r0.sv
// Directed testbench for the R0 register-file RAM.
module tb_r0;

    logic       clk;
    logic       rst_n;
    logic [1:0] adr;
    logic [3:0] data_in;
    logic [3:0] RAM_out;

    int total;
    int bad;

    r0 #(
        .ADDR_W (2),
        .DATA_W (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .adr     (adr),
        .data_in (data_in),
        .RAM_out (RAM_out)
    );

    // Clock is pulsed explicitly: the RAM writes on every edge, so a
    // free-running clock would hide the "hold while clk is low" checks.
    task automatic tick();
        #5 clk = 1'b1;
        #5 clk = 1'b0;
        #1;
    endtask

    task automatic set_adr(input logic [1:0] a);
        adr = a;
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] exp);
        total++;
        assert (RAM_out === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, RAM_out, exp);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        clk     = 1'b0;
        rst_n   = 1'b0;
        adr     = 2'd0;
        data_in = 4'h0;
        #3;

        // Reset: every word reads zero while reset is held.
        for (int i = 0; i < 4; i++) begin
            set_adr(2'(i));
            check($sformatf("rst_hold_adr%0d", i), 4'h0);
        end
        rst_n = 1'b1;
        #2;
        for (int i = 0; i < 4; i++) begin
            set_adr(2'(i));
            check($sformatf("rst_rel_adr%0d", i), 4'h0);
        end

        // Write word 0, then change data_in with clk low: no write happens.
        adr = 2'd0; data_in = 4'b0001;
        tick();
        check("wr_w0", 4'b0001);
        data_in = 4'b0000;
        #1;
        check("w0_hold_clk_low", 4'b0001);

        // Write word 1, then read back combinationally.
        adr = 2'd1; data_in = 4'b0010;
        tick();
        check("wr_w1", 4'b0010);
        set_adr(2'd0);
        check("rd_w0", 4'b0001);
        set_adr(2'd1);
        check("rd_w1", 4'b0010);

        // Isolation: writes to words 2 and 3 leave words 0 and 1 alone.
        adr = 2'd2; data_in = 4'hA;
        tick();
        check("wr_w2", 4'hA);
        adr = 2'd3; data_in = 4'h5;
        tick();
        check("wr_w3", 4'h5);
        set_adr(2'd0);
        check("iso_w0", 4'b0001);
        set_adr(2'd1);
        check("iso_w1", 4'b0010);
        set_adr(2'd2);
        check("iso_w2", 4'hA);

        // Overwrite word 0; neighbours unaffected.
        adr = 2'd0; data_in = 4'hF;
        tick();
        check("ovw_w0", 4'hF);
        set_adr(2'd1);
        check("ovw_w1", 4'b0010);
        set_adr(2'd3);
        check("ovw_w3", 4'h5);
        set_adr(2'd2);
        check("ovw_w2", 4'hA);

        // Asynchronous reset between edges clears the array at once.
        rst_n = 1'b0;
        #1;
        check("async_rst_w2", 4'h0);
        for (int i = 0; i < 4; i++) begin
            set_adr(2'(i));
            check($sformatf("async_rst_adr%0d", i), 4'h0);
        end

        // Edge during reset must not write.
        adr = 2'd0; data_in = 4'hF;
        tick();
        check("edge_in_rst", 4'h0);

        // Clean deassertion: next edge performs a normal write.
        rst_n = 1'b1;
        #1;
        check("post_rst_w0", 4'h0);
        adr = 2'd1; data_in = 4'h7;
        tick();
        check("post_rst_wr_w1", 4'h7);
        set_adr(2'd0);
        check("post_rst_w0_clear", 4'h0);
        set_adr(2'd3);
        check("post_rst_w3_clear", 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_r0
